ram_stream_reader: RTL and testbench
====================================

Name: ram_stream_reader

Overview:
- Read-side controller for the single-port `ram` block.
- On a start pulse it walks a contiguous address range, absorbs the RAM read latency, and emits each word on a valid/ready stream with full backpressure support.
- Used to play back RAM contents (coefficient tables, captured samples) into stream-based datapaths.

Parameters:
- MEM_WIDTH, 16, data word width; must equal the RAM word width.
- MEM_DEPTH, 66, RAM depth in words.
- READ_LATENCY, 1, RAM read latency in cycles. 0 = distributed (combinational) read; 1 = block (registered) read. Any other value fails elaboration with $error.
- ADDR_WIDTH, $clog2(MEM_DEPTH), address width.
- LEN_WIDTH, ADDR_WIDTH+1, transfer length width.

Ports:
- clk_i  input  1  clock
- arstn_i  input  1  reset, asynchronous, active-low
- start_i  input  1  one-cycle start pulse; ignored while busy_o=1
- base_addr_i  input  ADDR_WIDTH  first address, sampled on an accepted start_i
- len_i  input  LEN_WIDTH  number of words, sampled on an accepted start_i; 0 means no transfer
- busy_o  output  1  transfer in progress
- done_o  output  1  one-cycle pulse after the last word handshakes
- mem_addr_o  output  ADDR_WIDTH  RAM read address
- mem_data_i  input  MEM_WIDTH  RAM read data
- m_tdata_o  output  MEM_WIDTH  stream data
- m_tvalid_o  output  1  stream valid
- m_tlast_o  output  1  marks the final word of a transfer
- m_tready_i  input  1  stream ready

Behaviour:
- Reset (arstn_i=0, asynchronous): state IDLE; busy_o=0, done_o=0, m_tvalid_o=0, m_tlast_o=0, mem_addr_o=0, m_tdata_o=0. Buffer empty, counters cleared.
- Reset asserted mid-transfer aborts immediately. No done_o pulse. Buffered words are discarded.
- FSM states:
  - IDLE: on start_i with len_i≠0, latch base and length; go to READ; busy_o=1 from the next cycle. On start_i with len_i=0, stay in IDLE and pulse done_o the next cycle.
  - READ: issue reads. Move to DRAIN when the issue counter reaches len.
  - DRAIN: wait until all issued words have handshaken. Then return to IDLE, drop busy_o, and pulse done_o in the same cycle.
- Read issue: one address per cycle, and only while (buffer occupancy + reads in flight) < 2. In-flight reads never overflow the buffer.
- mem_addr_o increments per issued read. Wrap from MEM_DEPTH-1 to 0; for non-power-of-2 depths use explicit compare, not natural overflow.
- Data return:
  - READ_LATENCY=0: word captured in the same cycle the address is presented.
  - READ_LATENCY=1: word captured one cycle after its address.
  - A valid pipe of READ_LATENCY stages tracks in-flight reads.
- Output buffer: 2-entry FIFO.
  - Output is m_tvalid_o = not empty.
  - Handshake occurs when m_tvalid_o && m_tready_i.
  - m_tdata_o and m_tlast_o stay stable while valid is high and ready is low.
- Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.
- m_tlast_o is asserted with the word whose index equals len-1.
- Throughput: 1 word/cycle sustained with m_tready_i held high. First m_tvalid_o appears 1+READ_LATENCY cycles after start_i.

Optional Feature:
- Macro: RAM_STREAM_READER_LOOP_EN.
- Defined:
  - Adds input port loop_i (1 bit), sampled with start_i.
  - If loop_i was 1, the transfer repeats the same range indefinitely; m_tlast_o still marks each pass.
  - No done_o pulse between passes, and no bubble between passes while ready is held high.
  - Loop stops only on reset, or when loop_i=0 is observed at a pass boundary; the current pass then completes normally with done_o.
- Not defined: no loop_i port; every transfer is single-shot.

Decomposition:
- Package ram_stream_reader_pkg:
  - state_t enum (IDLE, READ, DRAIN).
  - BUF_DEPTH=2 constant.
  - function next_addr(addr, depth) implementing the wrap.
- Sub-module stream_fifo2: the 2-entry output buffer with valid/ready, parameterised on width (MEM_WIDTH+1 to carry last).

Test Plan:
- Single-shot, READ_LATENCY=1, RAM preloaded with data=addr+0x100, base=3, len=5, ready=1 -> tdata 0x103..0x107 on consecutive cycles; tlast on 0x107; done_o one cycle after the last handshake.
- Wrap: MEM_DEPTH=66, base=64, len=4 -> addresses 64, 65, 0, 1; data in that order.
- Backpressure: len=8, ready toggled 1,0,0,1 repeating -> exactly 8 handshakes, in order; tdata stable during stalls; no word lost or duplicated.
- len=0 start -> busy_o stays 0, no tvalid, done_o pulses once.
- Reset mid-transfer: arstn_i low after the 3rd handshake of len=10 -> outputs return to reset values immediately; a following start with base=0, len=2 completes cleanly.
- READ_LATENCY=0 with loop (macro defined): base=0, len=3, loop_i=1, ready=1 -> continuous sequence 0,1,2,0,1,2...; tlast every third word; no done_o.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and helpers for the RAM playback reader.
// FSM state encoding, output buffer depth and the non-power-of-2 address wrap.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 2;

    // Explicit compare so depths that are not a power of two wrap correctly.
    function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
        return (addr >= depth - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/ram_stream_reader_stream_fifo2.sv
// Two-entry valid/ready output buffer; head entry drives the stream directly.
module stream_fifo2 #(
    parameter int WIDTH = 17
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] head_q, tail_q;
    logic [1:0]       count_q;
    logic             pop;

    assign pop     = ready_i && (count_q != 2'd0);
    assign valid_o = (count_q != 2'd0);
    assign head_o  = head_q;
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case ({push_i, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= push_data_i;
                    else                 tail_q <= push_data_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Push and pop together: occupancy unchanged, queue shifts forward.
                    if (count_q == 2'd1) begin
                        head_q <= push_data_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous RAM range on start_i and streams each word out with valid/ready/last.
// Build option RAM_STREAM_READER_LOOP_EN adds loop_i for continuous replay of the range.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int MEM_WIDTH    = 16,
    parameter int MEM_DEPTH    = 66,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
    parameter int LEN_WIDTH    = ADDR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
`ifdef RAM_STREAM_READER_LOOP_EN
    input  logic                  loop_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [MEM_WIDTH-1:0]  mem_data_i,
    output logic [MEM_WIDTH-1:0]  m_tdata_o,
    output logic                  m_tvalid_o,
    output logic                  m_tlast_o,
    input  logic                  m_tready_i
);

    localparam int FW = MEM_WIDTH + 1;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q, base_q;
    logic                  done_q;

    logic                  accept, accept_run, hs, credit_ok, issue, issue_last;
    logic                  restart, all_issued, finish, loop_next;
    logic [LEN_WIDTH-1:0]  issue_idx, issue_len;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  push, push_last, inflight;
    logic [1:0]            count;
    logic [2:0]            pending;
    logic [FW-1:0]         head;

    assign accept     = (state_q == IDLE) && start_i;
    assign accept_run = accept && (len_i != '0);
    assign hs         = m_tvalid_o && m_tready_i;

    // The first read goes out in the accepting cycle so the word appears 1+READ_LATENCY later.
    assign mem_addr_o = accept_run ? base_addr_i : addr_q;
    assign addr_nxt   = ADDR_WIDTH'(next_addr(32'(mem_addr_o), 32'(MEM_DEPTH)));

    // A word popped this cycle frees its slot for a read issued this cycle.
    assign pending    = {1'b0, count} + {2'b00, inflight};
    assign credit_ok  = pending < (3'(BUF_DEPTH) + {2'b00, hs});

    assign issue_idx  = accept ? '0 : cnt_q;
    assign issue_len  = accept ? len_i : len_q;
    assign issue      = accept_run || ((state_q == READ) && (cnt_q != len_q) && credit_ok);
    assign issue_last = issue && (issue_idx == issue_len - LEN_WIDTH'(1));
    assign restart    = issue_last && loop_next;

    assign all_issued = (state_q != IDLE) && (cnt_q == len_q);
    assign finish     = all_issued && hs && (count == 2'd1) && !inflight;

`ifdef RAM_STREAM_READER_LOOP_EN
    logic loop_q;

    assign loop_next = accept ? loop_i : (loop_q && loop_i);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)                      loop_q <= 1'b0;
        else if (accept_run || issue_last) loop_q <= loop_next;
    end
`else
    assign loop_next = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_run) state_d = READ;
            READ: begin
                if (finish)          state_d = IDLE;
                else if (all_issued) state_d = DRAIN;
            end
            DRAIN:   if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (accept && (len_i == '0)) || finish;
            if (accept_run) begin
                len_q  <= len_i;
                base_q <= base_addr_i;
            end
            if (issue) begin
                cnt_q  <= restart ? '0 : issue_idx + LEN_WIDTH'(1);
                addr_q <= restart ? base_q : addr_nxt;
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_lat0
            assign push      = issue;
            assign push_last = issue_last;
            assign inflight  = 1'b0;
        end else if (READ_LATENCY == 1) begin : g_lat1
            logic vld_p1, last_p1;

            // Stage p1: address registered by the RAM, data arrives next cycle
            always_ff @(posedge clk_i or negedge arstn_i) begin
                if (!arstn_i) begin
                    vld_p1  <= 1'b0;
                    last_p1 <= 1'b0;
                end else begin
                    vld_p1  <= issue;
                    last_p1 <= issue_last;
                end
            end

            assign push      = vld_p1;
            assign push_last = last_p1;
            assign inflight  = vld_p1;
        end else begin : g_bad_latency
            $error("ram_stream_reader: READ_LATENCY must be 0 or 1");
        end
    endgenerate

    stream_fifo2 #(
        .WIDTH(FW)
    ) u_buf (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .push_i      (push),
        .push_data_i ({push_last, mem_data_i}),
        .ready_i     (m_tready_i),
        .valid_o     (m_tvalid_o),
        .head_o      (head),
        .count_o     (count)
    );

    assign m_tdata_o = head[MEM_WIDTH-1:0];
    assign m_tlast_o = m_tvalid_o && head[MEM_WIDTH];
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: block-RAM (latency 1) and distributed-RAM (latency 0) instances
// share stimulus; each stream is scored against a queue built from base/len/wrap rules.
module tb_ram_stream_reader;

    localparam int W = 16, DEPTH = 66, AW = 7, LW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arstn = 1'b0, start = 1'b0, ready = 1'b0, loop = 1'b0;
    logic [AW-1:0] base = '0;
    logic [LW-1:0] len = '0;
    logic [W-1:0]  ram [DEPTH];

    logic          busy1, done1, vld1, last1, busy0, done0, vld0, last0;
    logic [AW-1:0] addr1, addr0;
    logic [W-1:0]  rdata1, rdata0, tdata1, tdata0;

    always @(posedge clk) rdata1 <= ram[addr1];
    assign rdata0 = ram[addr0];

    ram_stream_reader #(.MEM_WIDTH(W), .MEM_DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
        .clk_i(clk), .arstn_i(arstn), .start_i(start), .base_addr_i(base), .len_i(len),
`ifdef RAM_STREAM_READER_LOOP_EN
        .loop_i(loop),
`endif
        .busy_o(busy1), .done_o(done1), .mem_addr_o(addr1), .mem_data_i(rdata1),
        .m_tdata_o(tdata1), .m_tvalid_o(vld1), .m_tlast_o(last1), .m_tready_i(ready));

    ram_stream_reader #(.MEM_WIDTH(W), .MEM_DEPTH(DEPTH), .READ_LATENCY(0)) dut0 (
        .clk_i(clk), .arstn_i(arstn), .start_i(start), .base_addr_i(base), .len_i(len),
`ifdef RAM_STREAM_READER_LOOP_EN
        .loop_i(loop),
`endif
        .busy_o(busy0), .done_o(done0), .mem_addr_o(addr0), .mem_data_i(rdata0),
        .m_tdata_o(tdata0), .m_tvalid_o(vld0), .m_tlast_o(last0), .m_tready_i(ready));

    int n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected {last, data} per stream, in stream order.
    logic [W:0] q0[$], q1[$];

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [W:0] qpop(input int d);
        if (d == 0) return (q0.size() != 0) ? q0.pop_front() : 'x;
        return (q1.size() != 0) ? q1.pop_front() : 'x;
    endfunction

    task automatic push_pass(input int d, input int b, input int l);
        for (int i = 0; i < l; i++) begin
            logic [W:0] e;
            e = {1'(i == l - 1), ram[(b + i) % DEPTH]};
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Monitor state
    int   cyc = 0;
    int   hs_cnt[2], first_hs[2], last_hs[2];
    bit   prev_stall[2], hs_last_prev[2], loop_active[2];
    logic [W-1:0] prev_data[2];
    bit   zero_exp = 0, loop_mode = 0;
    int   loop_base = 0, loop_len = 3;
    int   ready_mode = 0, pat = 0;

    task automatic mon_dut(input int d);
        logic v, l, dn, h;
        logic [W-1:0] td;
        logic [W:0] e;
        v  = d ? vld1  : vld0;
        l  = d ? last1 : last0;
        dn = d ? done1 : done0;
        td = d ? tdata1 : tdata0;
        if (loop_mode && loop_active[d] && qsize(d) < 2 * loop_len) push_pass(d, loop_base, loop_len);
        if (prev_stall[d]) begin
            check_eq($sformatf("stall_valid[%0d]", d), 32'(v), 32'd1);
            check_eq($sformatf("stall_data[%0d]", d), 32'(td), 32'(prev_data[d]));
        end
        if (!loop_mode) begin
            check_eq($sformatf("done[%0d]", d), 32'(dn), 32'(hs_last_prev[d] | zero_exp));
        end else begin
            check_eq($sformatf("loop_done[%0d]", d), 32'(dn && (!hs_last_prev[d] || loop)), 32'd0);
            if (dn) loop_active[d] = 0;
        end
        h = v && ready;
        if (h) begin
            e = qpop(d);
            check_eq($sformatf("tdata[%0d]", d), 32'(td), 32'(e[W-1:0]));
            check_eq($sformatf("tlast[%0d]", d), 32'(l), 32'(e[W]));
            hs_cnt[d]++;
            if (first_hs[d] < 0) first_hs[d] = cyc;
            last_hs[d] = cyc;
        end
        hs_last_prev[d] = h && l;
        prev_stall[d]   = v && !ready;
        prev_data[d]    = td;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!arstn) begin
            for (int d = 0; d < 2; d++) begin
                prev_stall[d]   = 0;
                hs_last_prev[d] = 0;
            end
        end else begin
            mon_dut(0);
            mon_dut(1);
        end
    end

    // 0: ready held high, 1: pattern 1,0,0,1, 2: random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = (pat % 4 == 0) || (pat % 4 == 3);
            default: ready = 1'($urandom_range(0, 1));
        endcase
        pat++;
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},  {busy1, busy0},   2'b00);
        check_eq({tag, "_done"},  {done1, done0},   2'b00);
        check_eq({tag, "_valid"}, {vld1, vld0},     2'b00);
        check_eq({tag, "_last"},  {last1, last0},   2'b00);
        check_eq({tag, "_addr"},  {addr1, addr0},   '0);
        check_eq({tag, "_tdata"}, {tdata1, tdata0}, '0);
    endtask

    task automatic start_xfer(input int b, input int l, input bit lp);
        push_pass(0, b, l);
        push_pass(1, b, l);
        base  = AW'(b);
        len   = LW'(l);
        loop  = lp;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1) && n < budget) begin
            @(posedge clk);
            #1 n++;
        end
        check_eq({tag, "_completes_in_budget"}, 32'(n < budget), 32'd1);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int h0, h1, n;
        for (int i = 0; i < DEPTH; i++) ram[i] = W'(i + 'h100);
        for (int d = 0; d < 2; d++) begin
            hs_cnt[d] = 0; first_hs[d] = -1; last_hs[d] = -1; loop_active[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        arstn = 1'b1;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Single shot, base 3 len 5, ready high: latency 1+READ_LATENCY, then 1 word/cycle
        first_hs[0] = -1; first_hs[1] = -1;
        start_xfer(3, 5, 0);
        check_eq("busy_after_start", {busy1, busy0}, 2'b11);
        @(negedge clk);
        #1 check_eq("first_valid_lat0", 32'(vld0), 32'd1);
        check_eq("first_valid_lat1_early", 32'(vld1), 32'd0);
        @(negedge clk);
        #1 check_eq("first_valid_lat1", 32'(vld1), 32'd1);
        wait_idle("single", 100);
        check_eq("throughput_lat1", 32'(last_hs[1] - first_hs[1]), 32'd4);
        check_eq("throughput_lat0", 32'(last_hs[0] - first_hs[0]), 32'd4);
        check_eq("idle_after_single", {busy1, busy0}, 2'b00);

        // Address wrap 64,65,0,1
        start_xfer(64, 4, 0);
        wait_idle("wrap", 100);

        // Backpressure 1,0,0,1 with exactly 8 handshakes
        ready_mode = 1;
        h0 = hs_cnt[0]; h1 = hs_cnt[1];
        start_xfer(10, 8, 0);
        wait_idle("backpressure", 200);
        check_eq("bp_count_lat0", 32'(hs_cnt[0] - h0), 32'd8);
        check_eq("bp_count_lat1", 32'(hs_cnt[1] - h1), 32'd8);

        // Zero-length start: stays idle, one done pulse
        ready_mode = 0;
        start_xfer(5, 0, 0);
        zero_exp = 1;
        check_eq("zero_len_busy", {busy1, busy0}, 2'b00);
        check_eq("zero_len_valid", {vld1, vld0}, 2'b00);
        @(posedge clk);
        #1 zero_exp = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset after the third handshake of a 10-word transfer
        ready_mode = 2;
        h1 = hs_cnt[1];
        start_xfer(20, 10, 0);
        n = 0;
        while (hs_cnt[1] - h1 < 3 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check_eq("third_handshake_seen", 32'(n < 200), 32'd1);
        arstn = 1'b0;
        #1 check_reset_outputs("midreset");
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1 arstn = 1'b1;
        @(posedge clk);
        #1 start_xfer(0, 2, 0);
        wait_idle("after_reset", 100);

        // Randomized transfers under random backpressure
        for (int t = 0; t < 10; t++) begin
            start_xfer($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), 0);
            wait_idle($sformatf("random%0d", t), 400);
        end

`ifdef RAM_STREAM_READER_LOOP_EN
        // Looped replay of 0,1,2 with no done until loop_i drops
        ready_mode = 0;
        loop_base = 0; loop_len = 3;
        loop_active[0] = 1; loop_active[1] = 1;
        loop_mode = 1;
        start_xfer(0, 3, 1);
        repeat (20) @(posedge clk);
        #1 loop = 1'b0;
        n = 0;
        while ((loop_active[0] || loop_active[1]) && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check_eq("loop_stops", 32'(n < 100), 32'd1);
        check_eq("loop_pass_complete0", 32'(q0.size() % 3), 32'd0);
        check_eq("loop_pass_complete1", 32'(q1.size() % 3), 32'd0);
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1 loop_mode = 0;
        check_eq("loop_idle", {busy1, busy0}, 2'b00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
